// File: rtl/sseg_scan_if.sv
// sseg_scan_if -- connection between a seven-segment display scanner and
// whatever controls it.
//
// Signals:
//   digit_en   [3:0]  per-digit enable (bit i = 0 keeps anode i dark)
//   hold              freezes scanning on the current digit while high
//   bright     [1:0]  brightness level, present only with SSEG_SCAN_DIM_EN
//   dp         [1:0]  current digit index (segment multiplexer select)
//   an         [3:0]  active-low anode enables
//   frame_tick        one-cycle pulse on each 3->0 wrap of dp
//
// Modports:
//   master  controller side: drives digit_en/hold(/bright), observes outputs
//   slave   scanner side:    receives controls, drives dp/an/frame_tick
//
// Optional feature macro: SSEG_SCAN_DIM_EN (adds bright).
interface sseg_scan_if;
  logic [3:0] digit_en;
  logic       hold;
  logic [1:0] dp;
  logic [3:0] an;
  logic       frame_tick;
`ifdef SSEG_SCAN_DIM_EN
  logic [1:0] bright;

  modport master (output digit_en, hold, bright, input dp, an, frame_tick);
  modport slave  (input digit_en, hold, bright, output dp, an, frame_tick);
`else
  modport master (output digit_en, hold, input dp, an, frame_tick);
  modport slave  (input digit_en, hold, output dp, an, frame_tick);
`endif
endinterface

// File: rtl/sseg_scan.sv
// sseg_scan -- four-digit seven-segment anode scanner.
//
// Each digit gets a slot of PRESCALE clocks. The first BLANK_CYCLES clocks of
// a slot keep every anode dark (anti-ghosting), the rest light anode dp when
// digit_en[dp] is set. dp advances at the end of each slot unless hold was
// high at that edge; frame_tick pulses for the cycle after dp wraps 3->0.
//
// Parameters:
//   PRESCALE      clocks per digit slot (>= BLANK_CYCLES + 4)
//   BLANK_CYCLES  dark clocks at the start of each slot (>= 1)
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   sseg_scan_if.slave (digit_en, hold, [bright], dp, an, frame_tick)
//
// Optional feature macro: SSEG_SCAN_DIM_EN -- adds bright[1:0]; the lit part
// of the ON phase is limited to (bright+1) quarters, bright = 3 lights it all.
module sseg_scan #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  sseg_scan_if.slave bus
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST      = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  typedef enum logic {BLANK = 1'b0, ON = 1'b1} stateT;

  stateT         state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic [1:0]    dpReg, dpNext;
  logic [3:0]    anReg, anNext;
  logic          tickReg, tickNext;
  logic          wrap;
  logic          lit;

`ifdef SSEG_SCAN_DIM_EN
  localparam int DIM_Q = (PRESCALE - BLANK_CYCLES) / 4;
  localparam logic [CW-1:0] LIM1 = CW'(DIM_Q);
  localparam logic [CW-1:0] LIM2 = CW'(2 * DIM_Q);
  localparam logic [CW-1:0] LIM3 = CW'(3 * DIM_Q);

  logic [1:0]    brightReg, brightNext;
  logic [CW-1:0] onOffset;
`endif

  assign wrap = (cnt == LAST);

  always_comb begin
    cntNext   = wrap ? '0 : cnt + 1'b1;
    dpNext    = dpReg;
    tickNext  = 1'b0;
    stateNext = state;
    lit       = 1'b1;
    anNext    = 4'hF;

    // A held wrap is simply lost; nothing is queued for later.
    if (wrap && !bus.hold) begin
      dpNext   = dpReg + 2'd1;
      tickNext = (dpReg == 2'd3);
    end

    case (state)
      BLANK:   if (cntNext == BLANK_END) stateNext = ON;
      ON:      if (wrap) stateNext = BLANK;
      default: stateNext = BLANK;
    endcase

`ifdef SSEG_SCAN_DIM_EN
    // Brightness is latched on the edge that starts a slot and held for it.
    brightNext = wrap ? bus.bright : brightReg;
    // Only meaningful once in ON; in BLANK the anodes are dark anyway.
    onOffset   = cntNext - BLANK_END;
    case (brightNext)
      2'd0:    lit = (onOffset < LIM1);
      2'd1:    lit = (onOffset < LIM2);
      2'd2:    lit = (onOffset < LIM3);
      default: lit = 1'b1;
    endcase
`endif

    // Anodes are decoded from the next cnt/dp so they switch on the very
    // edge that crosses the BLANK/ON boundary or changes dp.
    if (stateNext == ON && bus.digit_en[dpNext] && lit)
      anNext[dpNext] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BLANK;
      cnt       <= '0;
      dpReg     <= 2'd0;
      anReg     <= 4'hF;
      tickReg   <= 1'b0;
`ifdef SSEG_SCAN_DIM_EN
      brightReg <= 2'd3;
`endif
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      dpReg     <= dpNext;
      anReg     <= anNext;
      tickReg   <= tickNext;
`ifdef SSEG_SCAN_DIM_EN
      brightReg <= brightNext;
`endif
    end
  end

  assign bus.dp         = dpReg;
  assign bus.an         = anReg;
  assign bus.frame_tick = tickReg;

endmodule
